// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared states, opcodes and PC source codes for the multi-cycle controller
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [1:0] PC_SRC_SEQ = 2'd0;
  localparam logic [1:0] PC_SRC_BR  = 2'd1;
  localparam logic [1:0] PC_SRC_JMP = 2'd2;

  // True for every opcode the controller knows how to sequence
  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_R) || (op == OP_J) || (op == OP_BEQ) || (op == OP_BNE) ||
           (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_timeout.sv
// rtl/multicycle_ctrl_mem_timeout.sv - wait-cycle counter that flags the last permitted memory wait cycle
module multicycle_ctrl_mem_timeout #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // Number of completed waiting cycles of the current access
  logic [15:0] r_cnt;

  // Clear on a new access, otherwise count one per unanswered request cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // High during the LIMIT-th waiting cycle; an ack in that same cycle still wins
  assign expired = (r_cnt == 16'(LIMIT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle fetch/decode/exec/mem/wb control FSM with shared RAM port
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             halt_req,
  input  logic [5:0]       op,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_sel_inst,
  output logic             ir_load,
  output logic             pc_load,
  output logic [1:0]       pc_src,
  output logic             reg_we,
  output logic             busy,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] retired
);

  state_t           r_state;
  state_t           w_next;
  logic             r_illegal;
  logic             r_bus_err;
  logic [CNT_W-1:0] r_retired;
  logic             w_retire;
  logic             w_set_illegal;
  logic             w_set_bus_err;
  logic             w_expired;
  logic             w_to_clr;
  logic             w_to_en;

  // Restart the wait count whenever a new access begins, count unanswered request cycles
  assign w_to_clr = (w_next != r_state) && ((w_next == ST_FETCH) || (w_next == ST_MEM));
  assign w_to_en  = mem_req && !mem_ack;

  multicycle_ctrl_mem_timeout #(
    .LIMIT(TIMEOUT)
  ) u_mem_timeout (
    .clk    (clk),
    .reset  (reset),
    .clr    (w_to_clr),
    .en     (w_to_en),
    .expired(w_expired)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state, memory handshake and datapath strobes
  always_comb begin
    w_next        = r_state;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_sel_inst  = 1'b0;
    ir_load       = 1'b0;
    pc_load       = 1'b0;
    pc_src        = PC_SRC_SEQ;
    reg_we        = 1'b0;
    w_retire      = 1'b0;
    w_set_illegal = 1'b0;
    w_set_bus_err = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (run) w_next = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req      = 1'b1;
        mem_sel_inst = 1'b1;
        if (mem_ack) begin
          ir_load = 1'b1;
          pc_load = 1'b1;
          w_next  = ST_DECODE;
        end else if (w_expired) begin
          w_set_bus_err = 1'b1;
          w_next        = ST_HALT;
        end
      end
      ST_DECODE: begin
        if (op_legal(op)) begin
          w_next = ST_EXEC;
        end else begin
          w_set_illegal = 1'b1;
          w_next        = ST_HALT;
        end
      end
      ST_EXEC: begin
        case (op)
          OP_LW, OP_SW: w_next = ST_MEM;
          OP_BEQ: begin
            pc_load  = zero;
            pc_src   = PC_SRC_BR;
            w_retire = 1'b1;
          end
          OP_BNE: begin
            pc_load  = !zero;
            pc_src   = PC_SRC_BR;
            w_retire = 1'b1;
          end
          OP_J: begin
            pc_load  = 1'b1;
            pc_src   = PC_SRC_JMP;
            w_retire = 1'b1;
          end
          default: w_next = ST_WB;
        endcase
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (op == OP_SW);
        if (mem_ack) begin
          if (op == OP_SW) w_retire = 1'b1;
          else             w_next   = ST_WB;
        end else if (w_expired) begin
          w_set_bus_err = 1'b1;
          w_next        = ST_HALT;
        end
      end
      ST_WB: begin
        reg_we   = 1'b1;
        w_retire = 1'b1;
      end
      ST_HALT: begin
        w_next = ST_HALT;
      end
      default: w_next = ST_IDLE;
    endcase
    // Instruction boundary: a halt request in the retiring cycle returns to IDLE
    if (w_retire) w_next = halt_req ? ST_IDLE : ST_FETCH;
  end

  // Sticky fault flags and wrapping retired-instruction counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
      r_retired <= '0;
    end else begin
      if (w_set_illegal) r_illegal <= 1'b1;
      if (w_set_bus_err) r_bus_err <= 1'b1;
      if (w_retire)      r_retired <= r_retired + 1'b1;
    end
  end

  assign busy    = (r_state != ST_IDLE) && (r_state != ST_HALT);
  assign illegal = r_illegal;
  assign bus_err = r_bus_err;
  assign retired = r_retired;

endmodule
